// File: rtl/alu_cmd_issuer.sv
// Switch/button front end for the ALU: synchronizes and debounces the buttons,
// holds operands A/B and issues one valid/ready command per execute press.
// Optional auto-repeat while execute is held: define ALU_CMD_REPEAT_EN.
//
// state  | meaning
// S_IDLE | waiting for load/exec pulses, busy=0
// S_ISSUE| command presented on op_valid, waiting for op_ready, busy=1
module alu_cmd_issuer #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] sw_data,
   input  logic [3:0] sw_op,
   input  logic       sw_sel,
   input  logic       btn_load,
   input  logic       btn_exec,
   output logic       op_valid,
   input  logic       op_ready,
   output logic [3:0] op_code,
   output logic [7:0] op_a,
   output logic [7:0] op_b,
   output logic       busy,
   output logic [7:0] exec_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t state, state_n;

   // index 0 = load button, index 1 = exec button
   logic [1:0]      sync1, sync2, deb, deb_d, pulse;
   logic [DB_W-1:0] db_cnt [2];

   logic load_en, issue_en, done, rep_fire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         pulse <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= {btn_exec, btn_load};
         sync2 <= sync1;
         deb_d <= deb;
         pulse <= deb & ~deb_d;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef ALU_CMD_REPEAT_EN
   localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

   logic [RP_W-1:0] rep_cnt;
   logic            rep_armed;

   // armed only by a handshake while exec is still held; a release disarms it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
      end else if (!deb[1]) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
      end else if (done) begin
         rep_cnt   <= RP_W'(REPEAT_CYCLES - 1);
         rep_armed <= 1'b1;
      end else if (state == S_IDLE && rep_armed && rep_cnt != '0) begin
         rep_cnt <= rep_cnt - 1'b1;
      end
   end

   assign rep_fire = (state == S_IDLE) && rep_armed && deb[1] && (rep_cnt == '0);
`else
   logic unused_repeat;
   assign unused_repeat = ^REPEAT_CYCLES;
   assign rep_fire      = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      load_en  = 1'b0;
      issue_en = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            load_en = pulse[0];
            if (pulse[1] || rep_fire) begin
               issue_en = 1'b1;
               state_n  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (op_ready) begin
               done    = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // decoded from the state register so an async reset drops op_valid at once
   assign op_valid = (state == S_ISSUE);
   assign busy     = (state == S_ISSUE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a       <= '0;
         op_b       <= '0;
         op_code    <= '0;
         exec_count <= '0;
      end else begin
         if (load_en) begin
            if (sw_sel) op_b <= sw_data;
            else        op_a <= sw_data;
         end
         if (issue_en) op_code <= sw_op;
         if (done)     exec_count <= exec_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized self-checking bench for alu_cmd_issuer with a scoreboard model of
// operands, issued commands and handshake count.
module tb_alu_cmd_issuer;

   localparam int DB = 4;
   localparam int RP = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sw_data;
   logic [3:0] sw_op;
   logic       sw_sel;
   logic       btn_load;
   logic       btn_exec;
   logic       op_valid;
   logic       op_ready;
   logic [3:0] op_code;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       busy;
   logic [7:0] exec_count;

   alu_cmd_issuer #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
      .clk(clk), .reset(reset), .sw_data(sw_data), .sw_op(sw_op), .sw_sel(sw_sel),
      .btn_load(btn_load), .btn_exec(btn_exec), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_a(op_a), .op_b(op_b), .busy(busy), .exec_count(exec_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model
   logic [7:0]  m_a, m_b;
   int          m_count;
   logic [19:0] exp_q[$];

   // observations, sampled on the falling edge before the handshake edge
   logic [19:0] obs_q[$];
   int          hs_count = 0;
   int          valid_rises = 0;
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      if (!reset && op_valid && op_ready) begin
         obs_q.push_back({op_code, op_a, op_b});
         hs_count++;
      end
      if (op_valid && !prev_valid) valid_rises++;
      prev_valid = op_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(output bit ok);
      for (int k = 0; k < 40; k++) begin
         if (op_valid) break;
         tick(1);
      end
      ok = op_valid;
   endtask

   task automatic press_load(input logic sel, input logic [7:0] data);
      sw_sel   = sel;
      sw_data  = data;
      btn_load = 1'b1;
      tick(DB + 5);
      btn_load = 1'b0;
      tick(DB + 6);
      if (sel) m_b = data;
      else     m_a = data;
   endtask

   task automatic test_reset();
      checks++;
      if ({op_valid, busy, op_code, op_a, op_b, exec_count} !== 30'd0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%0b busy=%0b code=%h a=%h b=%h cnt=%h required all 0",
                  op_valid, busy, op_code, op_a, op_b, exec_count);
      end
      reset = 1'b0;
      tick(5);
      checks++;
      if ({op_valid, busy, exec_count} !== 10'd0) begin
         failures++;
         $display("FAIL reset_release: got v=%0b busy=%0b cnt=%h required 0", op_valid, busy, exec_count);
      end
      m_a = 8'h00; m_b = 8'h00; m_count = 0;
   endtask

   task automatic test_load();
      int r0;
      r0       = valid_rises;
      sw_sel   = 1'b0;
      sw_data  = 8'h5A;
      btn_load = 1'b1;
      tick(DB + 3);
      checks++;
      if (op_a !== 8'h00) begin
         failures++;
         $display("FAIL load_early: op_a=%h before edge %0d required 00", op_a, DB + 3);
      end
      tick(1);
      checks++;
      if (op_a !== 8'h5A) begin
         failures++;
         $display("FAIL load_edge: op_a=%h at edge %0d required 5a", op_a, DB + 3);
      end
      checks++;
      if (op_b !== 8'h00) begin
         failures++;
         $display("FAIL load_b_untouched: op_b=%h required 00", op_b);
      end
      tick(12 - (DB + 4));
      btn_load = 1'b0;
      tick(DB + 6);
      m_a = 8'h5A;
      for (int i = 0; i < 6; i++)
         press_load(1'($urandom_range(0, 1)), 8'($urandom));
      checks++;
      if (op_a !== m_a || op_b !== m_b) begin
         failures++;
         $display("FAIL load_random: a=%h b=%h required a=%h b=%h", op_a, op_b, m_a, m_b);
      end
      checks++;
      if (valid_rises !== r0) begin
         failures++;
         $display("FAIL load_no_valid: valid rises=%0d required %0d", valid_rises - r0, 0);
      end
   endtask

   task automatic test_bounce_exec();
      int r0;
      bit ok;
      r0       = valid_rises;
      op_ready = 1'b0;
      sw_op    = 4'h3;
      for (int i = 0; i < 2; i++) begin
         btn_exec = 1'b1; tick(2);
         btn_exec = 1'b0; tick(2);
      end
      tick(4);
      checks++;
      if (valid_rises !== r0 || op_valid !== 1'b0) begin
         failures++;
         $display("FAIL bounce_quiet: valid rises=%0d required 0", valid_rises - r0);
      end
      btn_exec = 1'b1;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bounce_issue: op_valid=0 after held press required 1");
      end
      tick(3);
      checks++;
      if (valid_rises !== r0 + 1) begin
         failures++;
         $display("FAIL bounce_single: valid rises=%0d required 1", valid_rises - r0);
      end
      checks++;
      if (op_code !== 4'h3 || op_a !== m_a || op_b !== m_b || busy !== 1'b1) begin
         failures++;
         $display("FAIL bounce_cmd: code=%h a=%h b=%h busy=%0b required code=3 a=%h b=%h busy=1",
                  op_code, op_a, op_b, busy, m_a, m_b);
      end
      exp_q.push_back({4'h3, m_a, m_b});
   endtask

   task automatic test_issue_hold();
      logic [19:0] o, e;
      tick(5);
      sw_op    = 4'h7;
      sw_sel   = 1'b0;
      sw_data  = ~m_a;
      btn_load = 1'b1;
      tick(DB + 5);
      btn_load = 1'b0;
      tick(DB + 6);
      checks++;
      if (op_valid !== 1'b1 || op_code !== 4'h3 || op_a !== m_a || op_b !== m_b) begin
         failures++;
         $display("FAIL hold_stable: v=%0b code=%h a=%h b=%h required v=1 code=3 a=%h b=%h",
                  op_valid, op_code, op_a, op_b, m_a, m_b);
      end
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      m_count++;
      checks++;
      if (op_valid !== 1'b0 || exec_count !== 8'(m_count)) begin
         failures++;
         $display("FAIL hold_handshake: v=%0b cnt=%h required v=0 cnt=%h", op_valid, exec_count, 8'(m_count));
      end
      btn_exec = 1'b0;
      tick(DB + 6);
      checks++;
      if (obs_q.size() != exp_q.size() || obs_q.size() == 0) begin
         failures++;
         $display("FAIL hold_sb_size: observed=%0d required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL hold_sb: got %h required %h", o, e);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_simultaneous();
      bit ok;
      logic [3:0] opc;
      logic [19:0] o, e;
      opc      = 4'($urandom);
      op_ready = 1'b0;
      sw_sel   = 1'b1;
      sw_data  = 8'hC3;
      sw_op    = opc;
      btn_load = 1'b1;
      btn_exec = 1'b1;
      wait_valid(ok);
      m_b = 8'hC3;
      checks++;
      if (!ok || op_b !== 8'hC3 || op_code !== opc || op_a !== m_a) begin
         failures++;
         $display("FAIL simul_cmd: v=%0b code=%h a=%h b=%h required v=1 code=%h a=%h b=c3",
                  op_valid, op_code, op_a, op_b, opc, m_a);
      end
      exp_q.push_back({opc, m_a, m_b});
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      m_count++;
      btn_load = 1'b0;
      btn_exec = 1'b0;
      tick(DB + 6);
      checks++;
      if (exec_count !== 8'(m_count) || obs_q.size() != 1) begin
         failures++;
         $display("FAIL simul_count: cnt=%h hs=%0d required cnt=%h hs=1", exec_count, obs_q.size(), 8'(m_count));
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL simul_sb: got %h required %h", o, e);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random_traffic();
      bit ok;
      bit pre;
      int d;
      logic [19:0] o, e;
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            press_load(1'($urandom_range(0, 1)), 8'($urandom));
         end else begin
            pre      = 1'($urandom_range(0, 1));
            d        = int'($urandom_range(0, 6));
            sw_op    = 4'($urandom);
            op_ready = pre;
            btn_exec = 1'b1;
            wait_valid(ok);
            checks++;
            if (!ok) begin
               failures++;
               $display("FAIL rand_issue: op_valid=0 after press required 1");
            end
            exp_q.push_back({sw_op, m_a, m_b});
            sw_op   = 4'($urandom);
            sw_data = 8'($urandom);
            sw_sel  = 1'($urandom_range(0, 1));
            if (!pre) begin
               tick(d);
               op_ready = 1'b1;
            end
            tick(1);
            m_count++;
            checks++;
            if (op_valid !== 1'b0) begin
               failures++;
               $display("FAIL rand_drop: op_valid=%0b after handshake required 0", op_valid);
            end
            op_ready = 1'b0;
            btn_exec = 1'b0;
            tick(DB + 6);
         end
      end
      checks++;
      if (obs_q.size() != exp_q.size() || exec_count !== 8'(m_count)) begin
         failures++;
         $display("FAIL rand_count: hs=%0d cnt=%h required hs=%0d cnt=%h",
                  obs_q.size(), exec_count, exp_q.size(), 8'(m_count));
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL rand_sb: got %h required %h", o, e);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_wrap();
      bit ok;
      int iter;
      logic [19:0] o, e;
      iter = 0;
      do begin
         sw_op    = 4'($urandom);
         op_ready = 1'b1;
         btn_exec = 1'b1;
         wait_valid(ok);
         if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wrap_issue: op_valid=0 at handshake %0d required 1", m_count);
            break;
         end
         exp_q.push_back({sw_op, m_a, m_b});
         tick(1);
         m_count++;
         btn_exec = 1'b0;
         tick(DB + 4);
         if (8'(m_count) == 8'hFF) begin
            checks++;
            if (exec_count !== 8'hFF) begin
               failures++;
               $display("FAIL wrap_ff: cnt=%h required ff", exec_count);
            end
         end
         iter++;
      end while (8'(m_count) != 8'h00 && iter < 300);
      op_ready = 1'b0;
      tick(2);
      checks++;
      if (exec_count !== 8'h00 || 8'(m_count) != 8'h00) begin
         failures++;
         $display("FAIL wrap_zero: cnt=%h required 00", exec_count);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL wrap_sb_size: observed=%0d required %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL wrap_sb: got %h required %h", o, e);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_repeat();
      int h0, got, expn;
      logic [3:0] opc;
      logic [19:0] o;
      localparam int HOLD = 60;
`ifdef ALU_CMD_REPEAT_EN
      // first handshake at edge DB+4, then one per RP idle cycles plus the issue cycle
      expn = (HOLD - 1 - (DB + 4)) / (RP + 1) + 1;
`else
      expn = 1;
`endif
      opc      = 4'($urandom);
      sw_op    = opc;
      op_ready = 1'b1;
      h0       = hs_count;
      btn_exec = 1'b1;
      tick(HOLD);
      got = hs_count - h0;
      btn_exec = 1'b0;
      tick(DB + 6 + RP);
      op_ready = 1'b0;
      tick(2);
      checks++;
      if (got != expn) begin
         failures++;
         $display("FAIL repeat_count: handshakes=%0d required %0d", got, expn);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (o !== {opc, m_a, m_b}) begin
            failures++;
            $display("FAIL repeat_cmd: got %h required %h", o, {opc, m_a, m_b});
         end
      end
      m_count += hs_count - h0;
      exp_q.delete();
   endtask

   task automatic test_reset_mid_issue();
      bit ok;
      int h0;
      op_ready = 1'b0;
      sw_op    = 4'($urandom);
      btn_exec = 1'b1;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rst_mid_issue: op_valid=0 before reset required 1");
      end
      h0 = hs_count;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({op_valid, busy, op_code, op_a, op_b, exec_count} !== 30'd0) begin
         failures++;
         $display("FAIL rst_async: v=%0b busy=%0b code=%h a=%h b=%h cnt=%h required all 0",
                  op_valid, busy, op_code, op_a, op_b, exec_count);
      end
      op_ready = 1'b1;
      btn_exec = 1'b0;
      tick(3);
      reset = 1'b0;
      m_a = 8'h00; m_b = 8'h00; m_count = 0;
      tick(DB + 6);
      op_ready = 1'b0;
      checks++;
      if (hs_count != h0 || exec_count !== 8'h00 || op_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_txn: hs=%0d cnt=%h v=%0b required hs=0 cnt=00 v=0",
                  hs_count - h0, exec_count, op_valid);
      end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      reset    = 1'b1;
      sw_data  = 8'h00;
      sw_op    = 4'h0;
      sw_sel   = 1'b0;
      btn_load = 1'b0;
      btn_exec = 1'b0;
      op_ready = 1'b0;
      tick(3);
      test_reset();
      test_load();
      test_bounce_exec();
      test_issue_hold();
      test_simultaneous();
      test_random_traffic();
      test_wrap();
      test_repeat();
      test_reset_mid_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Front-end input controller for the switch-driven ALU. It turns raw board buttons and switches into clean, handshaked ALU commands. Both buttons are synchronized and debounced. Operand registers A and B are loaded from the data switches. Each execute press produces exactly one valid/ready transaction carrying the opcode and both operands. It sits between the board I/O pins and the ALU datapath.

## Interface
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a debounced button changes state (≥2)
- REPEAT_CYCLES, 5000000, auto-repeat interval in cycles; used only with ALU_CMD_REPEAT_EN
- clk  in  1  board clock
- reset  in  1  asynchronous, active-high reset
- sw_data  in  8  operand data switches
- sw_op  in  4  opcode switches
- sw_sel  in  1  operand select: 0 = A, 1 = B
- btn_load  in  1  raw load button (asynchronous, bouncy)
- btn_exec  in  1  raw execute button (asynchronous, bouncy)
- op_valid  out  1  command valid
- op_ready  in  1  ALU accepts command
- op_code  out  4  opcode captured at issue
- op_a  out  8  operand register A
- op_b  out  8  operand register B
- busy  out  1  high while in ISSUE
- exec_count  out  8  number of completed handshakes, wraps

## Operation
- Per button: 2-flop synchronizer, then debouncer.
  - Counter increments each cycle the synchronized input differs from the debounced state.
  - Counter clears on any cycle they match.
  - After DEBOUNCE_CYCLES consecutive mismatches, the debounced state flips and the counter clears.
- Registered rising-edge detector on each debounced signal gives a one-cycle pulse (load_p, exec_p).
- FSM states:
  - IDLE: busy=0.
    - load_p writes sw_data into A (sw_sel=0) or B (sw_sel=1).
    - exec_p captures sw_op into op_code → ISSUE.
  - ISSUE: op_valid=1, busy=1.
    - op_code, op_a and op_b are held stable.
    - load_p and exec_p are ignored (dropped, not queued).
    - On an edge with op_valid & op_ready: exec_count += 1 (mod 256) → IDLE.
- load_p and exec_p in the same IDLE cycle: both act at that edge; the issued command carries the newly loaded operand.
- op_ready in IDLE is ignored. op_ready may already be high when op_valid rises; the handshake then completes on the first edge after op_valid rises.
- sw_* changes outside a load or issue edge have no effect on outputs.

## Timing
- Reset (async assert) clears all of the following, and op_valid drops immediately, including mid-handshake:
  - op_valid=0, busy=0, op_code=0, op_a=0, op_b=0, exec_count=0
  - state IDLE, debounced states 0, all counters 0
- Edge 0 = first clk edge sampling the raw button high:
  - debounced state flips at edge D+1, where D = DEBOUNCE_CYCLES
  - pulse is high after edge D+2
  - operand write / op_valid assertion occurs at edge D+3
- Release is debounced identically. A new press is recognized only after a debounced release.
- op_valid deasserts on the handshake edge; minimum gap before the next op_valid is one cycle.

## Configuration
- ALU_CMD_REPEAT_EN defined:
  - While debounced exec stays high, a repeat timer runs in IDLE after each handshake.
  - After REPEAT_CYCLES cycles, it re-issues with the current sw_op.
  - Timer clears on debounced release or reset.
- Undefined: exactly one command per press; REPEAT_CYCLES is unused and no timer logic is synthesized.

## Test plan
Use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
- Reset asserted mid-ISSUE → op_valid falls without a clock edge; all outputs 0; no transaction counted.
- sw_sel=0, sw_data=0x5A, btn_load high 12 cycles → op_a=0x5A at edge 7; op_b=0x00; op_valid never rises.
- btn_exec toggles every 2 cycles for 8 cycles, then held high with sw_op=0x3 → exactly one op_valid, with op_code=0x3; no op_valid during bounce.
- op_ready low 5 cycles while op_valid, sw_op changed to 0x7, btn_load pulsed → op_code stays 0x3 and operands unchanged; op_ready high → op_valid low next cycle, exec_count=1.
- Load (sw_sel=1, sw_data=0xC3) and exec pressed simultaneously → op_b=0xC3 visible when op_valid rises; 256 handshakes → exec_count wraps to 0x00.
- ALU_CMD_REPEAT_EN, btn_exec held, op_ready tied high → a handshake every 8 idle cycles plus handshake overhead; without the macro → a single handshake.
